// File: rtl/m55_bank_sched.sv
// Bank ownership scheduler for the four m55 state memories: hands banks to
// the loader, permuter and unloader in strict ring order.
module m55_bank_sched (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_req,
  input  logic       ld_done,
  output logic       ld_gnt,
  output logic       ld_own,
  output logic [1:0] ld_bank,
  input  logic       pm_req,
  input  logic       pm_done,
  output logic       pm_gnt,
  output logic       pm_own,
  output logic [1:0] pm_bank,
  input  logic       ul_req,
  input  logic       ul_done,
  output logic       ul_gnt,
  output logic       ul_own,
  output logic [1:0] ul_bank,
  output logic [2:0] occ,
  output logic       full,
  output logic       err
);

  localparam int NUM_BANKS  = 4;
  localparam int NUM_STAGES = 3;

  typedef enum logic [2:0] {
    B_FREE, B_LOADING, B_FULL, B_PERM, B_PERMD, B_UNLOAD
  } bank_st_e;

  // Stage index 0 = loader, 1 = permuter, 2 = unloader.
  function automatic bank_st_e src_st(input int s);
    case (s)
      0:       src_st = B_FREE;
      1:       src_st = B_FULL;
      default: src_st = B_PERMD;
    endcase
  endfunction

  function automatic bank_st_e busy_st(input int s);
    case (s)
      0:       busy_st = B_LOADING;
      1:       busy_st = B_PERM;
      default: busy_st = B_UNLOAD;
    endcase
  endfunction

  function automatic bank_st_e fin_st(input int s);
    case (s)
      0:       fin_st = B_FULL;
      1:       fin_st = B_PERMD;
      default: fin_st = B_FREE;
    endcase
  endfunction

  bank_st_e                        st   [NUM_BANKS];
  bank_st_e                        st_n [NUM_BANKS];
  logic [NUM_STAGES-1:0][1:0]      ptr, ptr_n;
  logic [NUM_STAGES-1:0]           own, own_n, gnt, gnt_n;
  logic [NUM_STAGES-1:0]           req, done;
  logic                            err_n;
  logic [2:0]                      occ_n;

  assign req  = {ul_req, pm_req, ld_req};
  assign done = {ul_done, pm_done, ld_done};

  // All decisions use pre-edge state, so a bank finished by one stage is only
  // visible to the next stage one edge later. Owning stages never share a bank.
  always_comb begin
    st_n  = st;
    ptr_n = ptr;
    own_n = own;
    gnt_n = '0;
    err_n = err;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (done[s]) begin
        if (own[s]) begin
          st_n[ptr[s]] = fin_st(s);
          ptr_n[s]     = ptr[s] + 2'd1;
          own_n[s]     = 1'b0;
        end else begin
          err_n = 1'b1;
        end
      end else if (req[s] && !own[s] && st[ptr[s]] == src_st(s)) begin
        st_n[ptr[s]] = busy_st(s);
        own_n[s]     = 1'b1;
        gnt_n[s]     = 1'b1;
      end
    end
    occ_n = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      occ_n = occ_n + 3'(st_n[b] != B_FREE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANKS; b++) st[b] <= B_FREE;
      ptr  <= '0;
      own  <= '0;
      gnt  <= '0;
      occ  <= '0;
      full <= 1'b0;
      err  <= 1'b0;
    end else begin
      st   <= st_n;
      ptr  <= ptr_n;
      own  <= own_n;
      gnt  <= gnt_n;
      occ  <= occ_n;
      full <= (occ_n == 3'd4);
      err  <= err_n;
    end
  end

  assign ld_gnt  = gnt[0];
  assign pm_gnt  = gnt[1];
  assign ul_gnt  = gnt[2];
  assign ld_own  = own[0];
  assign pm_own  = own[1];
  assign ul_own  = own[2];
  assign ld_bank = ptr[0];
  assign pm_bank = ptr[1];
  assign ul_bank = ptr[2];

endmodule

// File: tb/tb_m55_bank_sched.sv
// Self-checking bench for m55_bank_sched: block-count reference model plus
// directed scenarios and a randomized pipeline run.
module tb_m55_bank_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld_req, ld_done, pm_req, pm_done, ul_req, ul_done;
  logic       ld_gnt, ld_own, pm_gnt, pm_own, ul_gnt, ul_own;
  logic [1:0] ld_bank, pm_bank, ul_bank;
  logic [2:0] occ;
  logic       full, err;

  m55_bank_sched dut (
    .clk(clk), .reset(reset),
    .ld_req(ld_req), .ld_done(ld_done), .ld_gnt(ld_gnt), .ld_own(ld_own), .ld_bank(ld_bank),
    .pm_req(pm_req), .pm_done(pm_done), .pm_gnt(pm_gnt), .pm_own(pm_own), .pm_bank(pm_bank),
    .ul_req(ul_req), .ul_done(ul_done), .ul_gnt(ul_gnt), .ul_own(ul_own), .ul_bank(ul_bank),
    .occ(occ), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model in block counts: cnt[s] = blocks stage s has completed.
  // Block n lives in bank n%4; a stage may take block cnt[s] once the
  // upstream stage has completed it (loader: once block n-4 was unloaded).
  int cnt [3];
  bit m_own [3];
  bit m_gnt [3];
  bit m_err;

  task automatic model_edge(input bit rst, input bit [2:0] rq, input bit [2:0] dn);
    bit can [3];
    if (rst) begin
      for (int s = 0; s < 3; s++) begin cnt[s] = 0; m_own[s] = 0; m_gnt[s] = 0; end
      m_err = 0;
      return;
    end
    can[0] = (cnt[0] - cnt[2]) <= 3;
    can[1] = cnt[1] < cnt[0];
    can[2] = cnt[2] < cnt[1];
    for (int s = 0; s < 3; s++) begin
      m_gnt[s] = 0;
      if (dn[s]) begin
        if (m_own[s]) begin cnt[s]++; m_own[s] = 0; end
        else m_err = 1;
      end else if (rq[s] && !m_own[s] && can[s]) begin
        m_own[s] = 1;
        m_gnt[s] = 1;
      end
    end
  endtask

  function automatic int m_occ();
    return cnt[0] + int'(m_own[0]) - cnt[2];
  endfunction

  task automatic check_all();
    chk("ld_gnt", ld_gnt, m_gnt[0]);
    chk("pm_gnt", pm_gnt, m_gnt[1]);
    chk("ul_gnt", ul_gnt, m_gnt[2]);
    chk("ld_own", ld_own, m_own[0]);
    chk("pm_own", pm_own, m_own[1]);
    chk("ul_own", ul_own, m_own[2]);
    chk("ld_bank", ld_bank, cnt[0] % 4);
    chk("pm_bank", pm_bank, cnt[1] % 4);
    chk("ul_bank", ul_bank, cnt[2] % 4);
    chk("occ", occ, m_occ());
    chk("full", full, int'(m_occ() == 4));
    chk("err", err, m_err);
  endtask

  // One clock: drive inputs, take the edge, update model, check #1 after.
  task automatic step(input bit rst, input bit [2:0] rq, input bit [2:0] dn);
    reset   = rst;
    ld_req  = rq[0]; pm_req  = rq[1]; ul_req  = rq[2];
    ld_done = dn[0]; pm_done = dn[1]; ul_done = dn[2];
    @(posedge clk);
    model_edge(rst, rq, dn);
    #1;
    check_all();
    ld_done = 0; pm_done = 0; ul_done = 0;
  endtask

  initial begin
    bit [2:0] rq, dn;
    reset = 1; ld_req = 0; pm_req = 0; ul_req = 0;
    ld_done = 0; pm_done = 0; ul_done = 0;
    step(1, 3'b000, 3'b000);
    step(1, 3'b000, 3'b000);
    chk("rst_occ", occ, 0);
    chk("rst_err", err, 0);

    // First load: grant on bank 0, then done moves the loader to bank 1.
    step(0, 3'b001, 3'b000);
    chk("first_gnt", ld_gnt, 1);
    chk("first_bank", ld_bank, 0);
    chk("first_occ", occ, 1);
    step(0, 3'b000, 3'b000);
    chk("gnt_pulse", ld_gnt, 0);
    step(0, 3'b000, 3'b000);
    step(0, 3'b000, 3'b001);
    chk("ld_done_own", ld_own, 0);
    chk("ld_done_bank", ld_bank, 1);

    // Fill the ring with no pm/ul activity.
    for (int i = 0; i < 3; i++) begin
      step(0, 3'b001, 3'b000);
      step(0, 3'b000, 3'b001);
    end
    chk("ring_full", full, 1);
    chk("ring_occ", occ, 4);
    for (int i = 0; i < 3; i++) step(0, 3'b001, 3'b000);
    chk("ring_holdoff", ld_gnt, 0);
    // Drain block 0 through perm and unload; refill bank 0 one edge after ul_done.
    step(0, 3'b011, 3'b000);
    chk("pm_gnt_b0", pm_bank, 0);
    step(0, 3'b001, 3'b010);
    step(0, 3'b101, 3'b000);
    chk("ul_gnt_b0", ul_gnt, 1);
    step(0, 3'b001, 3'b100);
    chk("refill_not_yet", ld_gnt, 0);
    step(0, 3'b001, 3'b000);
    chk("refill_gnt", ld_gnt, 1);
    chk("refill_bank", ld_bank, 0);

    // Randomized traffic; done only pulses while the stage owns.
    for (int i = 0; i < 1500; i++) begin
      rq = 3'($urandom);
      for (int s = 0; s < 3; s++) dn[s] = m_own[s] && ($urandom_range(0, 2) == 0);
      step(0, rq, dn);
    end

    // Protocol error: stray pm_done; err sticks until reset.
    step(1, 3'b000, 3'b000);
    step(0, 3'b000, 3'b010);
    chk("err_set", err, 1);
    chk("err_nochg_occ", occ, 0);
    for (int i = 0; i < 3; i++) step(0, 3'b000, 3'b000);
    chk("err_sticky", err, 1);
    step(1, 3'b000, 3'b000);
    chk("err_clr", err, 0);

    // Reset mid-operation while loader and permuter both own.
    step(0, 3'b001, 3'b000);
    step(0, 3'b000, 3'b001);
    step(0, 3'b011, 3'b000);
    chk("mid_ld_own", ld_own, 1);
    chk("mid_pm_own", pm_own, 1);
    step(1, 3'b000, 3'b000);
    chk("mid_rst_own", {ld_own, pm_own, ul_own}, 0);
    chk("mid_rst_occ", occ, 0);
    step(0, 3'b001, 3'b000);
    chk("mid_regrant", ld_gnt, 1);
    chk("mid_regrant_bank", ld_bank, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
